// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
//   Shared constants, stage-register layouts and a helper for the ctrl_pipe
//   pipeline-control slice (ID/EX, EX/MEM, MEM/WB control registers plus the
//   hazard unit).
//   Optional feature macro used by the slice: FORWARD_EN.
//   No ports (package).

package ctrl_pipe_pkg;

    localparam int REG_W  = 5;  // register-specifier width
    localparam int CTRL_W = 4;  // alu_ctrl width

    // Branch field encodings as produced by the ID-stage decoder.
    // 2'b01 is unused and behaves like BR_NONE.
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BNE  = 2'b10,
        BR_BEQ  = 2'b11
    } branch_e;

    // ALU operand forwarding selects.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic              reg_write;
        logic              reg_dst;
        logic              alu_src;
        logic [1:0]        branch;
        logic              mem_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic [CTRL_W-1:0] alu_ctrl;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } idex_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             mem_read;
        logic [REG_W-1:0] dst;
    } exmem_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] dst;
    } memwb_t;

    // True when a producer destination collides with an ID-stage source.
    // $0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_conflict(
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// ctrl_pipe_hazard_unit
//   Combinational stall / flush / forwarding decisions for ctrl_pipe.
//   Macro FORWARD_EN: when defined, forwarding selects are produced and only
//   the load-use case stalls; otherwise every in-flight producer in EX or MEM
//   stalls a dependent instruction until it reaches WB.
// Ports
//   id_rs_i, id_rt_i, id_uses_rt_i   ID-stage source specifiers and rt usage
//   ex_branch_i, ex_zero_i           branch type in EX and ALU zero flag
//   ex_mem_read_i, ex_dst_i          EX-stage load flag and destination
//   mem_reg_write_i, mem_dst_i       MEM-stage producer
//   ex_rs_i, ex_rt_i, wb_*           (FORWARD_EN) forwarding inputs
//   ex_reg_write_i                   (no FORWARD_EN) EX-stage producer flag
//   pc_write_o, ifid_write_o         0 = hold PC / IF-ID
//   if_flush_o, branch_taken_o       taken-branch redirect
//   idex_bubble_o                    load a bubble into ID/EX
//   fwd_a_o, fwd_b_o                 (FORWARD_EN) operand selects

module ctrl_pipe_hazard_unit
    import ctrl_pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [1:0]       ex_branch_i,
    input  logic             ex_zero_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_dst_i,
    input  logic             mem_reg_write_i,
    input  logic [REG_W-1:0] mem_dst_i,
`ifdef FORWARD_EN
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             wb_reg_write_i,
    input  logic [REG_W-1:0] wb_dst_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
`else
    input  logic             ex_reg_write_i,
`endif
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             if_flush_o,
    output logic             branch_taken_o,
    output logic             idex_bubble_o
);

    logic taken;
    logic load_use;
    logic stall;

    assign taken = ((ex_branch_i == BR_BEQ) &&  ex_zero_i) ||
                   ((ex_branch_i == BR_BNE) && !ex_zero_i);

    assign load_use = ex_mem_read_i &
                      reg_conflict(ex_dst_i, id_rs_i, id_rt_i, id_uses_rt_i);

`ifdef FORWARD_EN
    assign stall = load_use;

    // One select per ALU operand; EX/MEM result is newer, so it wins.
    logic [REG_W-1:0] ex_src [2];
    logic [1:0]       fwd_sel [2];

    assign ex_src[0] = ex_rs_i;
    assign ex_src[1] = ex_rt_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = FWD_NONE;
                if (mem_reg_write_i && (mem_dst_i != '0) && (mem_dst_i == ex_src[gi])) begin
                    fwd_sel[gi] = FWD_MEM;
                end else if (wb_reg_write_i && (wb_dst_i != '0) && (wb_dst_i == ex_src[gi])) begin
                    fwd_sel[gi] = FWD_WB;
                end
            end
        end
    endgenerate

    assign fwd_a_o = fwd_sel[0];
    assign fwd_b_o = fwd_sel[1];
`else
    // Without forwarding a result is only visible once it is in WB (the
    // register file writes before it reads), so EX and MEM producers stall.
    assign stall = load_use |
                   (ex_reg_write_i  & reg_conflict(ex_dst_i,  id_rs_i, id_rt_i, id_uses_rt_i)) |
                   (mem_reg_write_i & reg_conflict(mem_dst_i, id_rs_i, id_rt_i, id_uses_rt_i));
`endif

    // A taken branch discards the ID instruction anyway, so it overrides
    // any stall and lets the fetch stream move to the target.
    assign pc_write_o     = taken | ~stall;
    assign ifid_write_o   = taken | ~stall;
    assign if_flush_o     = taken;
    assign branch_taken_o = taken;
    assign idex_bubble_o  = taken | stall;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
//   Carries decoded control fields through ID/EX, EX/MEM and MEM/WB, and
//   drives the PC / IF-ID write enables, IF flush and branch redirect from
//   the hazard unit.
//   Macro FORWARD_EN: enables operand forwarding selects (fwd_a/fwd_b);
//   without it they are constant 00 and dependent instructions stall.
// Ports
//   clock, resetn                     rising-edge clock, async active-low reset
//   id_*                              decoded controls and specifiers from ID
//   ex_zero                           ALU zero flag in EX
//   ex_alu_src/ex_alu_ctrl/ex_reg_dst EX-stage controls
//   ex_rs, ex_rt                      EX-stage source specifiers
//   mem_write, mem_read, mem_dst      MEM-stage controls and destination
//   wb_reg_write, wb_mem_to_reg, wb_dst  WB-stage controls and destination
//   pc_write, ifid_write, if_flush, branch_taken  fetch control
//   fwd_a, fwd_b                      operand forwarding selects

module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              id_reg_write,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic [1:0]        id_branch,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_zero,
    output logic              ex_alu_src,
    output logic [CTRL_W-1:0] ex_alu_ctrl,
    output logic              ex_reg_dst,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic              mem_write,
    output logic              mem_read,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  mem_dst,
    output logic [REG_W-1:0]  wb_dst,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              if_flush,
    output logic              branch_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic [REG_W-1:0] ex_dst;
    logic             id_uses_rt;
    logic             idex_bubble;

    assign ex_dst     = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
    // rt is a source for R-type ALU ops and as store data.
    assign id_uses_rt = ~id_alu_src | id_mem_write;

    ctrl_pipe_hazard_unit u_hazard (
        .id_rs_i         (id_rs),
        .id_rt_i         (id_rt),
        .id_uses_rt_i    (id_uses_rt),
        .ex_branch_i     (idex_q.branch),
        .ex_zero_i       (ex_zero),
        .ex_mem_read_i   (idex_q.mem_read),
        .ex_dst_i        (ex_dst),
        .mem_reg_write_i (exmem_q.reg_write),
        .mem_dst_i       (exmem_q.dst),
`ifdef FORWARD_EN
        .ex_rs_i         (idex_q.rs),
        .ex_rt_i         (idex_q.rt),
        .wb_reg_write_i  (memwb_q.reg_write),
        .wb_dst_i        (memwb_q.dst),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b),
`else
        .ex_reg_write_i  (idex_q.reg_write),
`endif
        .pc_write_o      (pc_write),
        .ifid_write_o    (ifid_write),
        .if_flush_o      (if_flush),
        .branch_taken_o  (branch_taken),
        .idex_bubble_o   (idex_bubble)
    );

`ifndef FORWARD_EN
    assign fwd_a = FWD_NONE;
    assign fwd_b = FWD_NONE;
`endif

    // A bubble clears the whole record; specifiers are zeroed too so a
    // bubble never looks like a forwarding consumer.
    always_comb begin
        idex_d = '0;
        if (!idex_bubble) begin
            idex_d.reg_write  = id_reg_write;
            idex_d.reg_dst    = id_reg_dst;
            idex_d.alu_src    = id_alu_src;
            idex_d.branch     = id_branch;
            idex_d.mem_write  = id_mem_write;
            idex_d.mem_to_reg = id_mem_to_reg;
            idex_d.mem_read   = id_mem_read;
            idex_d.alu_ctrl   = id_alu_ctrl;
            idex_d.rs         = id_rs;
            idex_d.rt         = id_rt;
            idex_d.rd         = id_rd;
        end
    end

    always_comb begin
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.dst        = ex_dst;

        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.dst        = exmem_q.dst;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alu_src    = idex_q.alu_src;
    assign ex_alu_ctrl   = idex_q.alu_ctrl;
    assign ex_reg_dst    = idex_q.reg_dst;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign mem_write     = exmem_q.mem_write;
    assign mem_read      = exmem_q.mem_read;
    assign mem_dst       = exmem_q.dst;
    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_dst        = memwb_q.dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe
//   Self-checking bench for ctrl_pipe. The bench acts as the fetch/decode
//   front end: it holds the ID instruction while its model says the pipe is
//   stalled and presents a NOP after a taken branch. Expected outputs come
//   from an instruction-level model (the last three instructions that entered
//   EX), plus hand-computed literal checks for directed programs.
//   Works in both builds (FORWARD_EN defined or not).

`define CHK(n, a, e) chk(n, 32'(a), 32'(e))

module tb_ctrl_pipe;

    typedef struct packed {
        logic       valid;  // real instruction (not an inserted bubble)
        logic       rw;
        logic       rdst;
        logic       asrc;
        logic [1:0] br;
        logic       mw;
        logic       m2r;
        logic       mr;
        logic [3:0] actl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clock;
    logic       resetn;
    logic       ex_zero;
    instr_t     id_in;

    logic       ex_alu_src, ex_reg_dst, mem_write, mem_read;
    logic       wb_reg_write, wb_mem_to_reg;
    logic       pc_write, ifid_write, if_flush, branch_taken;
    logic [3:0] ex_alu_ctrl;
    logic [4:0] ex_rs, ex_rt, mem_dst, wb_dst;
    logic [1:0] fwd_a, fwd_b;

    int unsigned n_cmp;
    int unsigned n_bad;
    int          cyc_no;

    // pipe[0] = instruction now in EX, pipe[1] = MEM, pipe[2] = WB
    instr_t pipe [3];
    instr_t m_enter;
    logic   m_stall;
    logic   m_taken;

    ctrl_pipe dut (
        .clock         (clock),
        .resetn        (resetn),
        .id_reg_write  (id_in.rw),
        .id_reg_dst    (id_in.rdst),
        .id_alu_src    (id_in.asrc),
        .id_branch     (id_in.br),
        .id_mem_write  (id_in.mw),
        .id_mem_to_reg (id_in.m2r),
        .id_mem_read   (id_in.mr),
        .id_alu_ctrl   (id_in.actl),
        .id_rs         (id_in.rs),
        .id_rt         (id_in.rt),
        .id_rd         (id_in.rd),
        .ex_zero       (ex_zero),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_ctrl   (ex_alu_ctrl),
        .ex_reg_dst    (ex_reg_dst),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .mem_dst       (mem_dst),
        .wb_dst        (wb_dst),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .if_flush      (if_flush),
        .branch_taken  (branch_taken),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc_no, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic rw, rdst, asrc, input logic [1:0] br,
                                  input logic mw, m2r, mr, input logic [3:0] actl,
                                  input logic [4:0] rs, rt, rd);
        instr_t i;
        i = '0;
        i.rw = rw; i.rdst = rdst; i.asrc = asrc; i.br = br;
        i.mw = mw; i.m2r = m2r; i.mr = mr; i.actl = actl;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t rand_instr();
        logic [4:0] s, t, d;
        logic [3:0] a;
        s = 5'($urandom_range(0, 3));
        t = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        a = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 6))
            0, 1:    return mk(1, 1, 0, 2'b00, 0, 0, 0, a, s, t, d);       // R-type
            2:       return mk(1, 0, 1, 2'b00, 0, 1, 1, 4'd2, s, t, 0);    // lw
            3:       return mk(0, 0, 1, 2'b00, 1, 0, 0, 4'd2, s, t, 0);    // sw
            4:       return mk(1, 0, 1, 2'b00, 0, 0, 0, a, s, t, 0);       // addi
            5:       return mk(0, 0, 0, $urandom_range(0, 1) ? 2'b11 : 2'b10,
                               0, 0, 0, 4'd6, s, t, 0);                     // beq/bne
            default: return instr_t'({1'b0, 26'($urandom)});               // arbitrary decode
        endcase
    endfunction

    function automatic logic [4:0] dst_of(input instr_t i);
        return i.rdst ? i.rd : i.rt;
    endfunction

    // Does a write to d feed a source operand of instruction c?
    function automatic logic hits(input logic [4:0] d, input instr_t c);
        return (d != 0) && ((d == c.rs) || ((!c.asrc || c.mw) && (d == c.rt)));
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (pipe[1].rw && dst_of(pipe[1]) != 0 && dst_of(pipe[1]) == src) return 2'b10;
        if (pipe[2].rw && dst_of(pipe[2]) != 0 && dst_of(pipe[2]) == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic reset_model();
        instr_t z;
        z = '0;
        z.valid = 1'b1;   // reset leaves all-zero stage registers
        for (int k = 0; k < 3; k++) pipe[k] = z;
    endtask

    // One cycle: present instruction i in ID, sample at the falling edge and
    // compare everything against the model. Leaves the model's decision in
    // m_stall / m_taken / m_enter for adv().
    task automatic step(input instr_t i, input logic z);
        instr_t ex, mm, wb, tmp;
        logic   stl, tkn;
        id_in   = i;
        ex_zero = z;
        @(negedge clock);
        ex = pipe[0]; mm = pipe[1]; wb = pipe[2];
        tkn = (ex.br == 2'b11 && z) || (ex.br == 2'b10 && !z);
        stl = ex.mr && hits(dst_of(ex), i);
        if (!FWD) stl = stl || (ex.rw && hits(dst_of(ex), i)) || (mm.rw && hits(dst_of(mm), i));

        `CHK("pc_write",      pc_write,      tkn || !stl);
        `CHK("ifid_write",    ifid_write,    tkn || !stl);
        `CHK("if_flush",      if_flush,      tkn);
        `CHK("branch_taken",  branch_taken,  tkn);
        `CHK("ex_alu_src",    ex_alu_src,    ex.asrc);
        `CHK("ex_alu_ctrl",   ex_alu_ctrl,   ex.actl);
        `CHK("ex_reg_dst",    ex_reg_dst,    ex.rdst);
        `CHK("mem_write",     mem_write,     mm.mw);
        `CHK("mem_read",      mem_read,      mm.mr);
        `CHK("wb_reg_write",  wb_reg_write,  wb.rw);
        `CHK("wb_mem_to_reg", wb_mem_to_reg, wb.m2r);
        if (ex.valid) begin
            `CHK("ex_rs", ex_rs, ex.rs);
            `CHK("ex_rt", ex_rt, ex.rt);
        end
        if (mm.valid) `CHK("mem_dst", mem_dst, dst_of(mm));
        if (wb.valid) `CHK("wb_dst",  wb_dst,  dst_of(wb));
        if (!FWD || ex.valid) begin
            `CHK("fwd_a", fwd_a, FWD ? fwd_model(ex.rs) : 2'b00);
            `CHK("fwd_b", fwd_b, FWD ? fwd_model(ex.rt) : 2'b00);
        end

        tmp = i;
        tmp.valid = 1'b1;
        m_enter = (tkn || stl) ? instr_t'('0) : tmp;
        m_stall = stl;
        m_taken = tkn;
        $display("cyc %0d id=%h z=%0d pcw=%0d ifidw=%0d flush=%0d fwd=%0d/%0d",
                 cyc_no, i, z, pc_write, ifid_write, if_flush, fwd_a, fwd_b);
        cyc_no++;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = m_enter;
    endtask

    // Keep presenting i until the model lets it into EX; returns the number
    // of cycles the DUT held the PC.
    task automatic issue(input instr_t i, input logic z, output int stalls);
        stalls = 0;
        for (int n = 0; n < 8; n++) begin
            step(i, z);
            if (!pc_write) stalls++;
            adv();
            if (!(m_stall && !m_taken)) return;
        end
        `CHK("issue_bound", 1, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 3; n++) begin
            step(nop(), 1'b0);
            adv();
        end
    endtask

    task automatic random_run(input int cycles);
        instr_t cur;
        cur = rand_instr();
        for (int c = 0; c < cycles; c++) begin
            step(cur, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (pc_write !== ifid_write) begin
                n_bad++;
                $display("FAIL pc_ifid_pair (cycle %0d): pc_write=%0d ifid_write=%0d, required equal",
                         cyc_no, pc_write, ifid_write);
            end
            n_cmp++;
            if (if_flush !== branch_taken) begin
                n_bad++;
                $display("FAIL flush_taken_pair (cycle %0d): if_flush=%0d branch_taken=%0d, required equal",
                         cyc_no, if_flush, branch_taken);
            end
            adv();
            if (m_taken)      cur = nop();
            else if (!m_stall) cur = rand_instr();
        end
    endtask

    initial begin
        int st;
        n_cmp   = 0;
        n_bad   = 0;
        cyc_no  = 0;
        resetn  = 1'b0;
        id_in   = '0;
        ex_zero = 1'b0;
        m_enter = '0;
        m_stall = 1'b0;
        m_taken = 1'b0;
        reset_model();

        // Reset state
        #3;
        `CHK("rst_pc_write",     pc_write,     1);
        `CHK("rst_ifid_write",   ifid_write,   1);
        `CHK("rst_if_flush",     if_flush,     0);
        `CHK("rst_branch_taken", branch_taken, 0);
        `CHK("rst_fwd_a",        fwd_a,        0);
        `CHK("rst_fwd_b",        fwd_b,        0);
        `CHK("rst_wb_reg_write", wb_reg_write, 0);
        `CHK("rst_mem_read",     mem_read,     0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // 1: lw $2,0($1); add $3,$2,$4
        issue(mk(1, 0, 1, 2'b00, 0, 1, 1, 4'd2, 5'd1, 5'd2, 5'd0), 1'b0, st);
        issue(mk(1, 1, 0, 2'b00, 0, 0, 0, 4'd2, 5'd2, 5'd4, 5'd3), 1'b0, st);
        `CHK("t1_stall_cycles", st, FWD ? 1 : 2);
        step(nop(), 1'b0);
        `CHK("t1_fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
        `CHK("t1_ex_rs", ex_rs, 2);
        adv();
        drain();

        // 2/3: add $2,$1,$1; sub $3,$2,$2
        issue(mk(1, 1, 0, 2'b00, 0, 0, 0, 4'd2, 5'd1, 5'd1, 5'd2), 1'b0, st);
        issue(mk(1, 1, 0, 2'b00, 0, 0, 0, 4'd6, 5'd2, 5'd2, 5'd3), 1'b0, st);
        `CHK("t2_stall_cycles", st, FWD ? 0 : 2);
        step(nop(), 1'b0);
        `CHK("t2_fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);
        `CHK("t2_fwd_b", fwd_b, FWD ? 2'b10 : 2'b00);
        adv();
        drain();

        // 4: beq taken with zero=1, then bne not taken with zero=1
        issue(mk(0, 0, 0, 2'b11, 0, 0, 0, 4'd6, 5'd1, 5'd1, 5'd0), 1'b0, st);
        step(mk(1, 0, 1, 2'b00, 0, 0, 0, 4'd5, 5'd0, 5'd5, 5'd0), 1'b1);
        `CHK("t4_beq_taken", branch_taken, 1);
        `CHK("t4_beq_flush", if_flush,     1);
        adv();
        step(nop(), 1'b0);
        `CHK("t4_ex_alu_ctrl", ex_alu_ctrl, 0);
        `CHK("t4_ex_alu_src",  ex_alu_src,  0);
        adv();
        issue(mk(0, 0, 0, 2'b10, 0, 0, 0, 4'd6, 5'd1, 5'd1, 5'd0), 1'b0, st);
        step(nop(), 1'b1);
        `CHK("t4_bne_taken", branch_taken, 0);
        `CHK("t4_bne_flush", if_flush,     0);
        adv();
        drain();

        // 5: EX holds a load-like op that is also a taken beq; ID depends on it
        issue(mk(1, 0, 1, 2'b11, 0, 1, 1, 4'd2, 5'd1, 5'd2, 5'd0), 1'b0, st);
        step(mk(1, 1, 0, 2'b00, 0, 0, 0, 4'd2, 5'd2, 5'd4, 5'd5), 1'b1);
        `CHK("t5_pc_write",   pc_write,   1);
        `CHK("t5_ifid_write", ifid_write, 1);
        `CHK("t5_if_flush",   if_flush,   1);
        adv();
        step(nop(), 1'b0);
        `CHK("t5_ex_alu_ctrl", ex_alu_ctrl, 0);
        adv();
        drain();

        // 6: add $0,$1,$1; sub $3,$0,$0
        issue(mk(1, 1, 0, 2'b00, 0, 0, 0, 4'd2, 5'd1, 5'd1, 5'd0), 1'b0, st);
        issue(mk(1, 1, 0, 2'b00, 0, 0, 0, 4'd6, 5'd0, 5'd0, 5'd3), 1'b0, st);
        `CHK("t6_stall_cycles", st, 0);
        step(nop(), 1'b0);
        `CHK("t6_fwd_a", fwd_a, 0);
        `CHK("t6_fwd_b", fwd_b, 0);
        adv();

        // Random traffic
        random_run(400);
        drain();

        // Reset in the middle of a full pipe: addi -> WB, lw -> MEM, sw -> EX
        issue(mk(1, 0, 1, 2'b00, 0, 0, 0, 4'd2, 5'd1, 5'd3, 5'd0), 1'b0, st);
        issue(mk(1, 0, 1, 2'b00, 0, 1, 1, 4'd2, 5'd1, 5'd2, 5'd0), 1'b0, st);
        issue(mk(0, 0, 1, 2'b00, 1, 0, 0, 4'd2, 5'd1, 5'd0, 5'd0), 1'b0, st);
        resetn = 1'b0;
        #1;
        `CHK("mrst_mem_read",      mem_read,      0);
        `CHK("mrst_mem_write",     mem_write,     0);
        `CHK("mrst_mem_dst",       mem_dst,       0);
        `CHK("mrst_wb_reg_write",  wb_reg_write,  0);
        `CHK("mrst_wb_mem_to_reg", wb_mem_to_reg, 0);
        `CHK("mrst_wb_dst",        wb_dst,        0);
        `CHK("mrst_ex_alu_src",    ex_alu_src,    0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        reset_model();

        random_run(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
